// File: rtl/axis_flit_serializer_credit.sv
`default_nettype none
// =============================================================================
// Module   : axis_flit_serializer_credit
// Purpose  : Buffers AXI-Stream beats, slices each into flits (LSB slice first)
//            and injects them into a router port under credit flow control.
// Revision : 1.0 - initial release
// =============================================================================
module axis_flit_serializer_credit #(
    parameter int TDATA_WIDTH          = 128,
    parameter int DEST_WIDTH           = 6,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int BUFFER_DEPTH         = 2,
    parameter int FLIT_BUFFER_DEPTH    = 8,
    localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR,
    localparam int CREDIT_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic [TDATA_WIDTH-1:0]  axis_tdata,
    input  logic                    axis_tlast,
    input  logic [DEST_WIDTH-1:0]   axis_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_err
);

    localparam int c_slice_w = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int c_ptr_w   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int c_occ_w   = $clog2(BUFFER_DEPTH + 1);
    localparam int c_entry_w = 1 + DEST_WIDTH + TDATA_WIDTH;

    localparam logic [c_slice_w-1:0]    c_last_slice = c_slice_w'(SERIALIZATION_FACTOR - 1);
    localparam logic [c_ptr_w-1:0]      c_ptr_max    = c_ptr_w'(BUFFER_DEPTH - 1);
    localparam logic [c_occ_w-1:0]      c_occ_full   = c_occ_w'(BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] c_credit_max = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_send = 1'b1;

    generate
        if ((SERIALIZATION_FACTOR < 1) || (TDATA_WIDTH % SERIALIZATION_FACTOR != 0)) begin : g_bad_factor
            $error("TDATA_WIDTH must be a multiple of SERIALIZATION_FACTOR (>=1)");
        end
        if ((BUFFER_DEPTH < 1) || (FLIT_BUFFER_DEPTH < 1)) begin : g_bad_depth
            $error("BUFFER_DEPTH and FLIT_BUFFER_DEPTH must be >= 1");
        end
    endgenerate

    logic [c_entry_w-1:0]   r_mem [BUFFER_DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_occ_w-1:0]     r_occ;
    logic [c_occ_w-1:0]     w_occ_next;
    logic [0:0]             r_state;
    logic [c_slice_w-1:0]   r_slice;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_can_send;
    logic                   w_last_slice;
    logic [c_entry_w-1:0]   w_head;
    logic [TDATA_WIDTH-1:0] w_head_data;
    logic [DEST_WIDTH-1:0]  w_head_dest;
    logic                   w_head_last;

    // Ready depends only on occupancy (and reset), never on tvalid.
    assign axis_tready  = !rst_noc && (r_occ < c_occ_full);
    assign w_push       = axis_tvalid && axis_tready;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_data  = w_head[TDATA_WIDTH-1:0];
    assign w_head_dest  = w_head[TDATA_WIDTH +: DEST_WIDTH];
    assign w_head_last  = w_head[c_entry_w-1];

    assign w_can_send   = (r_state == c_st_send) && (credit_count != '0);
    assign w_last_slice = (r_slice == c_last_slice);
    assign w_pop        = w_can_send && w_last_slice;

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 1'b1;
            2'b01:   w_occ_next = r_occ - 1'b1;
            default: w_occ_next = r_occ;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {axis_tlast, axis_tdest, axis_tdata};
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_state  <= c_st_idle;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_max) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_max) ? '0 : r_rd_ptr + 1'b1;
            end
            r_occ   <= w_occ_next;
            r_state <= (w_occ_next != '0) ? c_st_send : c_st_idle;
        end
    end

    // Flit output registers; the slice index only advances on an actual send.
    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            r_slice     <= '0;
            send_out    <= 1'b0;
            is_tail_out <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
        end else begin
            send_out <= w_can_send;
            if (w_can_send) begin
                data_out    <= w_head_data[r_slice*FLIT_WIDTH +: FLIT_WIDTH];
                dest_out    <= w_head_dest;
                is_tail_out <= w_last_slice && w_head_last;
                r_slice     <= w_last_slice ? '0 : r_slice + 1'b1;
            end else begin
                is_tail_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            credit_count <= c_credit_max;
            credit_err   <= 1'b0;
        end else begin
            if (credit_in && (credit_count == c_credit_max)) begin
                credit_err <= 1'b1;
            end
            case ({w_can_send, credit_in})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count != c_credit_max) begin
                        credit_count <= credit_count + 1'b1;
                    end
                end
                default: credit_count <= credit_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_flit_serializer_credit.sv
`default_nettype none
// Testbench for axis_flit_serializer_credit: directed scenarios plus random
// traffic checked against a flit-queue / credit-count reference model.
module tb_axis_flit_serializer_credit;

    localparam int TW  = 128;
    localparam int DW  = 6;
    localparam int SF  = 4;
    localparam int BD  = 2;
    localparam int FBD = 8;
    localparam int FW  = TW / SF;
    localparam int CW  = $clog2(FBD + 1);

    logic          clk_noc = 1'b0;
    logic          rst_noc = 1'b1;
    logic          axis_tvalid = 1'b0;
    logic          axis_tready;
    logic [TW-1:0] axis_tdata = '0;
    logic          axis_tlast = 1'b0;
    logic [DW-1:0] axis_tdest = '0;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credit_count;
    logic          credit_err;

    axis_flit_serializer_credit #(
        .TDATA_WIDTH(TW), .DEST_WIDTH(DW), .SERIALIZATION_FACTOR(SF),
        .BUFFER_DEPTH(BD), .FLIT_BUFFER_DEPTH(FBD)
    ) u_dut (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
        .axis_tlast(axis_tlast), .axis_tdest(axis_tdest),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in),
        .credit_count(credit_count), .credit_err(credit_err)
    );

    always #5 clk_noc = ~clk_noc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected flit stream plus beat/flit/credit bookkeeping.
    logic [FW+DW:0] exp_q[$];
    int m_acc   = 0;
    int m_flits = 0;
    int m_cred  = FBD;
    bit m_err   = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc   = 0;
        m_flits = 0;
        m_cred  = FBD;
        m_err   = 1'b0;
    endtask

    // One clock cycle: entered just after a falling edge, returns at the next one.
    task automatic step(input logic v, input logic [TW-1:0] d, input logic l,
                        input logic [DW-1:0] dst, input logic cr, output logic acc);
        int pre_occ, pre_cred;
        logic exp_send;
        logic [FW+DW:0] e;
        axis_tvalid = v; axis_tdata = d; axis_tlast = l; axis_tdest = dst; credit_in = cr;
        #1;
        pre_occ  = m_acc - m_flits / SF;
        pre_cred = m_cred;
        check("tready", axis_tready, pre_occ < BD);
        acc = v && (pre_occ < BD);
        @(posedge clk_noc); #1;
        exp_send = (pre_occ > 0) && (pre_cred > 0);
        check("send_out", send_out, exp_send);
        if (exp_send) begin
            e = exp_q.pop_front();
            if (send_out) begin
                check("data_out", data_out, e[FW-1:0]);
                check("dest_out", dest_out, e[FW +: DW]);
                check("is_tail_out", is_tail_out, e[FW+DW]);
            end
            m_flits++;
        end
        if (acc) begin
            for (int s = 0; s < SF; s++)
                exp_q.push_back({(s == SF-1) && l, dst, d[s*FW +: FW]});
            m_acc++;
        end
        if (cr && pre_cred == FBD) m_err = 1'b1;
        if (exp_send && !cr) m_cred--;
        else if (cr && !exp_send && pre_cred < FBD) m_cred++;
        check("credit_count", credit_count, m_cred);
        check("credit_err", credit_err, m_err);
        @(negedge clk_noc);
    endtask

    task automatic push_beat(input logic [TW-1:0] d, input logic l, input logic [DW-1:0] dst,
                             input logic cr, input int tries, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < tries && !ok; i++) step(1'b1, d, l, dst, cr, ok);
    endtask

    task automatic idle(input int n, input logic cr);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, cr, a);
    endtask

    function automatic logic [TW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic ok, pending, p_last, cr;
        logic [TW-1:0] p_data;
        logic [DW-1:0] p_dest;
        int guard;

        @(negedge clk_noc);
        check("rst_tready", axis_tready, 1'b0);
        check("rst_send", send_out, 1'b0);
        check("rst_data", data_out, '0);
        check("rst_credit", credit_count, FBD);
        check("rst_err", credit_err, 1'b0);
        rst_noc = 1'b0;

        // Single beat: slice i carries value i, tail on the 4th flit.
        push_beat({32'd3, 32'd2, 32'd1, 32'd0}, 1'b1, 6'h15, 1'b0, 2, ok);
        check("single_accept", ok, 1'b1);
        idle(5, 1'b0);
        check("single_credits", credit_count, 4);

        // Starvation: beat A consumes the last 4 credits, beat B waits mid-beat.
        push_beat(rand_data(), 1'b0, 6'h2a, 1'b0, 3, ok);
        check("starve_accept_a", ok, 1'b1);
        push_beat(rand_data(), 1'b1, 6'h2a, 1'b0, 3, ok);
        check("starve_accept_b", ok, 1'b1);
        idle(8, 1'b0);
        check("starve_zero", credit_count, 0);
        idle(1, 1'b1); idle(1, 1'b1);
        idle(5, 1'b0);
        check("starve_partial", m_flits, 10);
        idle(1, 1'b1); idle(1, 1'b1);
        idle(4, 1'b0);

        // Back-pressure: no credits, third beat must be held by tready.
        push_beat(rand_data(), 1'b0, 6'h01, 1'b0, 2, ok);
        check("bp_accept_1", ok, 1'b1);
        push_beat(rand_data(), 1'b0, 6'h02, 1'b0, 2, ok);
        check("bp_accept_2", ok, 1'b1);
        p_data = rand_data();
        push_beat(p_data, 1'b1, 6'h03, 1'b0, 4, ok);
        check("bp_hold_3", ok, 1'b0);
        push_beat(p_data, 1'b1, 6'h03, 1'b1, 20, ok);
        check("bp_accept_3", ok, 1'b1);
        idle(30, 1'b1);
        check("bp_drained", exp_q.size(), 0);
        check("err_sticky", credit_err, 1'b1);

        // Reset after the second flit of a beat.
        push_beat(rand_data(), 1'b1, 6'h3c, 1'b0, 2, ok);
        guard = 0;
        while ((m_flits % SF) != 2 && guard < 20) begin
            idle(1, 1'b0);
            guard++;
        end
        check("reset_reach_flit2", guard < 20, 1'b1);
        rst_noc = 1'b1;
        #1;
        check("mid_rst_send", send_out, 1'b0);
        check("mid_rst_data", data_out, '0);
        check("mid_rst_dest", dest_out, '0);
        check("mid_rst_credit", credit_count, FBD);
        check("mid_rst_err", credit_err, 1'b0);
        check("mid_rst_tready", axis_tready, 1'b0);
        model_reset();
        @(posedge clk_noc); #1;
        check("mid_rst_no_flit", send_out, 1'b0);
        @(negedge clk_noc);
        rst_noc = 1'b0;
        push_beat({32'hd, 32'hc, 32'hb, 32'ha}, 1'b1, 6'h07, 1'b0, 2, ok);
        check("post_rst_accept", ok, 1'b1);
        idle(5, 1'b0);

        // Random traffic with AXIS-compliant held beats and varying credit return rate.
        pending = 1'b0;
        p_last = 1'b0;
        p_dest = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pending && ($urandom % 3 != 0)) begin
                pending = 1'b1;
                p_data  = rand_data();
                p_last  = $urandom % 2;
                p_dest  = $urandom;
            end
            cr = (i % 200 < 100) ? ($urandom % 4 == 0) : ($urandom % 2 == 0);
            step(pending, p_data, p_last, p_dest, cr, ok);
            if (ok) pending = 1'b0;
        end
        idle(80, 1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
